seg7_product_receiver: RTL and testbench
========================================

# seg7_product_receiver

Receive end of the multiplier's multiplexed seven-segment display link. Samples the 7-bit segment bus and the LSB-digit select, filters glitches, decodes each settled pattern back to a hex nibble, and reassembles the 8-bit product. Each MSB-then-LSB digit pair produces one `o_valid` pulse. Used as the board-level/bench checker and as the front end of a display-snooping readback path.

## Interface
- `STABLE_CYCLES`, default 4: consecutive unchanged synchronized cycles required before a digit is accepted; legal range 1..255.
- `clk`  in  1: single clock; all state on its rising edge.
- `reset`  in  1: asynchronous, active-low; asserting it (0) clears all state immediately.
- `i_segments`  in  7: segment bus; bit0=a … bit6=g, active-high; asynchronous to `clk`.
- `i_lsb_digit`  in  1: digit select; 1 = bus shows product[3:0], 0 = bus shows product[7:4]; asynchronous to `clk`.
- `o_product`  out  8: last assembled product; held until the next valid pair.
- `o_valid`  out  1: one-cycle pulse when `o_product` updates.
- `o_seg_error`  out  1: one-cycle pulse when a settled non-blank pattern is not a legal hex glyph.

## Operation
- Synchronizer: two flops on all 8 input bits, with reset value 0 (blank, lsb=0).
- Stability filter:
  - Compare the synchronized 8-bit word with its previous-cycle value; on any difference, clear a saturating counter.
  - The word is *settled* when the counter reaches STABLE_CYCLES.
  - A phase is *armed* on every edge of the synchronized `lsb` and on reset exit. The first settled cycle of an armed phase is a capture event, after which the phase disarms.
  - Further segment changes within the same phase produce no second capture.
- Decode: legal glyphs are 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9, 0x77=A, 0x7C=b, 0x39=C, 0x5E=d, 0x79=E, 0x71=F.
  - Pattern 0x00 (blank): no capture, no error; the phase stays armed.
  - Any other pattern: illegal.
- FSM states: `WAIT_MSB` (reset state) and `HAVE_MSB`.
  - `WAIT_MSB`, capture with lsb=0, legal glyph: store the nibble in the MSB register and go to `HAVE_MSB`.
  - `WAIT_MSB`, capture with lsb=1: ignore and stay; there is no partial product.
  - `HAVE_MSB`, capture with lsb=1, legal glyph: set `o_product` = {msb, nibble}, pulse `o_valid`, go to `WAIT_MSB`.
  - `HAVE_MSB`, capture with lsb=0, legal glyph: overwrite the MSB register and stay.
  - Any capture with an illegal glyph: pulse `o_seg_error`, go to `WAIT_MSB`, leave `o_product` unchanged.
- Reset values: `o_product`=0x00, `o_valid`=0, `o_seg_error`=0, FSM=`WAIT_MSB`, counter=0, MSB register=0.
- Reset mid-operation discards any held MSB; the first LSB phase after reset is ignored.

## Timing
- Pin change (held stable) to capture-event register update: exactly STABLE_CYCLES+3 rising edges (2 sync + 1 compare + STABLE_CYCLES count).
- `o_valid` and the new `o_product` appear on the same edge.
- `o_seg_error` uses the same latency as `o_valid`. Both strobes are high for exactly one cycle and are never high together.
- Glitches shorter than STABLE_CYCLES+1 synchronized cycles are invisible.
- A glitch on `i_lsb_digit` alone that returns within the window re-arms the phase but yields the same capture; this is acceptable.
- Minimum supported phase length: STABLE_CYCLES+4 cycles. The transmitter's 1250-cycle phases meet this with large margin.

## Structure
- Package `seg7_pkg`:
  - 16 glyph constants and `SEG_BLANK`=7'h00.
  - FSM state enum.
  - Decode function returning {legal, nibble}.
  - The transmitter's segment table is rewritten to reference the same constants.
- Sub-module `seg7_decoder`: combinational, pattern → nibble, legal, blank.
- Top holds the synchronizer, stability counter, arm flag, FSM and output registers.

## Test plan
- Clean pair:
  - Stimulus: lsb=0 with seg 0x3F for 20 cycles, then lsb=1 with seg 0x71 for 20 cycles (3×5=15).
  - Response: `o_product`=0x0F; exactly one `o_valid`, arriving STABLE_CYCLES+3 edges after the lsb=1 change.
- Max product:
  - Stimulus: seg 0x4F with lsb=0, then 0x06 with lsb=1.
  - Response: `o_product`=0x31; repeating the pair gives one `o_valid` per pair.
- Glitch:
  - Stimulus: during the LSB phase, seg switches from 0x71 to 0x7F for STABLE_CYCLES-1 cycles and back.
  - Response: no extra capture; `o_product`=0x0F.
- Illegal glyph:
  - Stimulus: MSB 0x3F, then LSB pattern 0x7E held.
  - Response: one `o_seg_error` pulse, no `o_valid`, `o_product` keeps its prior value, FSM=`WAIT_MSB`.
- Ordering:
  - Stimulus: after reset, an LSB phase (0x06) arrives first.
  - Response: no `o_valid`; the following MSB/LSB pair decodes normally.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while in `HAVE_MSB`.
  - Response: all outputs 0 immediately, without waiting for a clock edge; the next LSB phase produces no `o_valid`.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph constants, receiver FSM state type and the glyph decode/encode
// helpers used by both ends of the seven-segment product link.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        WAIT_MSB = 1'b0,
        HAVE_MSB = 1'b1
    } rx_state_e;

    // Returns {legal, nibble}; blank and unknown patterns report legal=0.
    function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'h00;
        case (seg)
            SEG_0: r = {1'b1, 4'h0};
            SEG_1: r = {1'b1, 4'h1};
            SEG_2: r = {1'b1, 4'h2};
            SEG_3: r = {1'b1, 4'h3};
            SEG_4: r = {1'b1, 4'h4};
            SEG_5: r = {1'b1, 4'h5};
            SEG_6: r = {1'b1, 4'h6};
            SEG_7: r = {1'b1, 4'h7};
            SEG_8: r = {1'b1, 4'h8};
            SEG_9: r = {1'b1, 4'h9};
            SEG_A: r = {1'b1, 4'hA};
            SEG_B: r = {1'b1, 4'hB};
            SEG_C: r = {1'b1, 4'hC};
            SEG_D: r = {1'b1, 4'hD};
            SEG_E: r = {1'b1, 4'hE};
            SEG_F: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Transmitter-side segment table, built from the same constants.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_BLANK;
        case (nib)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational seven-segment pattern to hex nibble decoder with legal/blank flags.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    logic [4:0] dec;

    always_comb begin
        dec    = seg7_decode(seg);
        nibble = dec[3:0];
        legal  = dec[4];
        blank  = (seg == SEG_BLANK);
    end

endmodule

// File: rtl/seg7_product_receiver.sv
// Receive end of the multiplexed seven-segment product link: synchronize, settle,
// decode and reassemble MSB/LSB digit pairs into an 8-bit product.
module seg7_product_receiver
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_segments,
    input  logic       i_lsb_digit,
    output logic [7:0] o_product,
    output logic       o_valid,
    output logic       o_seg_error
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [7:0] prev_q,  prev_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       armed_q, armed_d;

    logic       word_changed;
    logic       lsb_edge;
    logic       settled;
    logic       capture;
    logic [3:0] nibble;
    logic       legal;
    logic       blank;

    rx_state_e  state_q;
    logic [3:0] msb_q;
    logic [7:0] product_q;
    logic       valid_q;
    logic       seg_err_q;

    // Word packs {lsb select, segments}; prev_q holds the settled candidate.
    seg7_decoder u_dec (
        .seg    (prev_q[6:0]),
        .nibble (nibble),
        .legal  (legal),
        .blank  (blank)
    );

    always_comb begin
        sync1_d      = {i_lsb_digit, i_segments};
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        word_changed = (sync2_q != prev_q);
        lsb_edge     = (sync2_q[7] != prev_q[7]);

        cnt_d = cnt_q;
        if (word_changed) begin
            cnt_d = 8'd0;
        end else if (cnt_q != STABLE_LIM) begin
            cnt_d = cnt_q + 8'd1;
        end

        // Capture on the edge where the counter first reaches the limit, so the
        // result lands STABLE_CYCLES+3 edges after the pin change.
        settled = !word_changed && (cnt_d == STABLE_LIM);
        capture = armed_q && settled && !blank;

        armed_d = armed_q;
        if (lsb_edge) begin
            armed_d = 1'b1;
        end else if (capture) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            prev_q  <= 8'h00;
            cnt_q   <= 8'h00;
            armed_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT_MSB;
            msb_q     <= 4'h0;
            product_q <= 8'h00;
            valid_q   <= 1'b0;
            seg_err_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            seg_err_q <= 1'b0;
            if (capture) begin
                if (!legal) begin
                    seg_err_q <= 1'b1;
                    state_q   <= WAIT_MSB;
                end else begin
                    case (state_q)
                        WAIT_MSB: begin
                            // An LSB digit with no preceding MSB is dropped.
                            if (!prev_q[7]) begin
                                msb_q   <= nibble;
                                state_q <= HAVE_MSB;
                            end
                        end
                        HAVE_MSB: begin
                            if (prev_q[7]) begin
                                product_q <= {msb_q, nibble};
                                valid_q   <= 1'b1;
                                state_q   <= WAIT_MSB;
                            end else begin
                                msb_q <= nibble;
                            end
                        end
                        default: state_q <= WAIT_MSB;
                    endcase
                end
            end
        end
    end

    assign o_product   = product_q;
    assign o_valid     = valid_q;
    assign o_seg_error = seg_err_q;

endmodule

// File: tb/tb_seg7_product_receiver.sv
// Directed self-checking bench for seg7_product_receiver with STABLE_CYCLES=4.
module tb_seg7_product_receiver;
    import seg7_pkg::*;

    localparam int S = 4;

    logic       clk;
    logic       reset;
    logic [6:0] i_segments;
    logic       i_lsb_digit;
    logic [7:0] o_product;
    logic       o_valid;
    logic       o_seg_error;

    int n_checks = 0;
    int n_fail   = 0;
    int both_hi  = 0;
    int nv, ne, fv, fe;

    seg7_product_receiver #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_segments  (i_segments),
        .i_lsb_digit (i_lsb_digit),
        .o_product   (o_product),
        .o_valid     (o_valid),
        .o_seg_error (o_seg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid && o_seg_error) both_hi++;
    end

    // Drive one phase; k counts edges after the pin change, sampled 1ns past each edge.
    task automatic run_phase(input logic lsb, input logic [6:0] seg, input int n);
        nv = 0; ne = 0; fv = 0; fe = 0;
        @(posedge clk); #1;
        i_lsb_digit = lsb;
        i_segments  = seg;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (o_valid) begin nv++; if (fv == 0) fv = k; end
            if (o_seg_error) begin ne++; if (fe == 0) fe = k; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; i_segments = 7'h00; i_lsb_digit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_product !== 8'h00) begin n_fail++; $display("FAIL reset_product got %h want 00", o_product); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
        n_checks++; if (o_seg_error !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", o_seg_error); end
        n_checks++; if (dut.state_q !== WAIT_MSB) begin n_fail++; $display("FAIL reset_state got %0d want WAIT_MSB", dut.state_q); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_clean_pair();
        run_phase(1'b0, 7'h3F, 20);
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL clean_msb_valid got %0d want 0", nv); end
        run_phase(1'b1, 7'h71, 20);
        n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL clean_valid_count got %0d want 1", nv); end
        n_checks++; if (fv !== S + 3) begin n_fail++; $display("FAIL clean_latency got %0d want %0d", fv, S + 3); end
        n_checks++; if (o_product !== 8'h0F) begin n_fail++; $display("FAIL clean_product got %h want 0f", o_product); end
    endtask

    task automatic test_max_product();
        for (int p = 0; p < 2; p++) begin
            run_phase(1'b0, 7'h4F, 20);
            run_phase(1'b1, 7'h06, 20);
            n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL max_valid_count[%0d] got %0d want 1", p, nv); end
            n_checks++; if (o_product !== 8'h31) begin n_fail++; $display("FAIL max_product[%0d] got %h want 31", p, o_product); end
        end
    endtask

    task automatic test_glitch();
        int tot;
        run_phase(1'b0, 7'h3F, 20);
        run_phase(1'b1, 7'h71, 12);
        tot = nv;
        run_phase(1'b1, 7'h7F, S - 1);
        tot += nv;
        run_phase(1'b1, 7'h71, 12);
        tot += nv;
        n_checks++; if (tot !== 1) begin n_fail++; $display("FAIL glitch_valid_count got %0d want 1", tot); end
        n_checks++; if (o_product !== 8'h0F) begin n_fail++; $display("FAIL glitch_product got %h want 0f", o_product); end
    endtask

    task automatic test_illegal();
        run_phase(1'b0, 7'h3F, 20);
        run_phase(1'b1, 7'h7E, 20);
        n_checks++; if (ne !== 1) begin n_fail++; $display("FAIL illegal_err_count got %0d want 1", ne); end
        n_checks++; if (fe !== S + 3) begin n_fail++; $display("FAIL illegal_latency got %0d want %0d", fe, S + 3); end
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL illegal_valid got %0d want 0", nv); end
        n_checks++; if (o_product !== 8'h0F) begin n_fail++; $display("FAIL illegal_product got %h want 0f", o_product); end
        n_checks++; if (dut.state_q !== WAIT_MSB) begin n_fail++; $display("FAIL illegal_state got %0d want WAIT_MSB", dut.state_q); end
    endtask

    task automatic test_ordering();
        @(posedge clk); #1;
        reset = 1'b0; i_segments = 7'h00; i_lsb_digit = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_phase(1'b1, 7'h06, 20);
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL order_lsb_first got %0d want 0", nv); end
        run_phase(1'b0, 7'h5B, 20);
        run_phase(1'b1, 7'h7D, 20);
        n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL order_pair_valid got %0d want 1", nv); end
        n_checks++; if (o_product !== 8'h26) begin n_fail++; $display("FAIL order_product got %h want 26", o_product); end
    endtask

    task automatic test_reset_mid();
        run_phase(1'b0, 7'h6D, 20);
        n_checks++; if (dut.state_q !== HAVE_MSB) begin n_fail++; $display("FAIL mid_pre_state got %0d want HAVE_MSB", dut.state_q); end
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        n_checks++; if (o_product !== 8'h00) begin n_fail++; $display("FAIL mid_async_product got %h want 00", o_product); end
        n_checks++; if (dut.state_q !== WAIT_MSB) begin n_fail++; $display("FAIL mid_async_state got %0d want WAIT_MSB", dut.state_q); end
        i_lsb_digit = 1'b1; i_segments = 7'h06;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        run_phase(1'b1, 7'h06, 20);
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL mid_lsb_after_reset got %0d want 0", nv); end
        run_phase(1'b0, 7'h77, 20);
        run_phase(1'b1, 7'h5E, 20);
        n_checks++; if (o_product !== 8'hAD) begin n_fail++; $display("FAIL mid_recover_product got %h want ad", o_product); end
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_clean_pair();
                test_max_product();
                test_glitch();
                test_illegal();
                test_ordering();
                test_reset_mid();
                n_checks++; if (both_hi !== 0) begin n_fail++; $display("FAIL strobe_overlap got %0d want 0", both_hi); end
            end
            begin
                #200000;
                $display("FAIL timeout got running want finished");
                $fatal(1, "timeout");
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
